// File: rtl/db_lcu_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : db_lcu_wr_ctrl
// Description : Upstream write controller for the deblocking luma LCU RAM.
//               Accepts reconstructed 4x4 blocks (one 128-bit word each) in
//               z-scan order over a valid/ready handshake, remaps the z-scan
//               index to a raster RAM address and drives a low-active RAM
//               write port. After the last block of the LCU it pulses done
//               and refuses input until the deblock stage releases the
//               buffer.
// Ports       : clk, rst        clock / asynchronous active-high reset
//               start_i         pulse: begin loading a new LCU
//               release_i       pulse: deblock has consumed the LCU buffer
//               blk_valid_i     input block valid
//               blk_ready_o     controller can accept a block (LOAD state)
//               blk_data_i      4x4 block pixels
//               cen_o, wen_o    RAM chip / write enable, low active
//               addr_o, data_o  RAM address / write data
//               done_o          pulse together with the final write strobe
//               busy_o          high in LOAD or WAIT
//               cnt_o           blocks accepted in the current LCU
// Revision    : 1.0 - initial release
// ============================================================================
module db_lcu_wr_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8,    // must be even when MAP_RASTER = 1
    parameter int BLK_NUM    = 256,  // 1 <= BLK_NUM <= 2**ADDR_WIDTH
    parameter int MAP_RASTER = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  release_i,
    input  logic                  blk_valid_i,
    output logic                  blk_ready_o,
    input  logic [DATA_WIDTH-1:0] blk_data_i,
    output logic                  cen_o,
    output logic                  wen_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH:0]   cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] c_last_blk = (ADDR_WIDTH+1)'(BLK_NUM - 1);

    state_t                  r_state;
    logic [ADDR_WIDTH:0]     r_cnt;
    logic                    r_cen;
    logic                    r_wen;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_done;
    logic                    r_busy;

    logic [ADDR_WIDTH-1:0]   w_map;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_last;

    // Ready is purely a function of state so the upstream sees it without
    // waiting a cycle; it is 0 under reset because reset forces IDLE.
    assign w_ready  = (r_state == LOAD);
    assign w_accept = blk_valid_i & w_ready;
    assign w_last   = (r_cnt == c_last_blk);

    // z-scan -> raster: even index bits form the column, odd bits the row.
    if (MAP_RASTER != 0) begin : g_raster
        localparam int H = ADDR_WIDTH / 2;
        for (genvar k = 0; k < H; k++) begin : g_bit
            assign w_map[k]     = r_cnt[2*k];
            assign w_map[H + k] = r_cnt[2*k + 1];
        end
    end else begin : g_linear
        assign w_map = r_cnt[ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Write port: one strobe cycle per accept, address/data hold
            // their last values between strobes.
            r_cen  <= ~w_accept;
            r_wen  <= ~w_accept;
            r_done <= w_accept & w_last;
            if (w_accept) begin
                r_addr <= w_map;
                r_data <= blk_data_i;
            end

            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A start arriving with the release chains straight
                    // into the next LCU without an IDLE bubble.
                    if (release_i) begin
                        if (start_i) begin
                            r_state <= LOAD;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign blk_ready_o = w_ready;
    assign cen_o       = r_cen;
    assign wen_o       = r_wen;
    assign addr_o      = r_addr;
    assign data_o      = r_data;
    assign done_o      = r_done;
    assign busy_o      = r_busy;
    assign cnt_o       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_db_lcu_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_db_lcu_wr_ctrl
// Description : Self-checking bench for db_lcu_wr_ctrl. A full-size instance
//               (256 blocks, raster map) covers full LCUs, bubbles, WAIT
//               hold, ignored controls and reset; a small instance
//               (4 blocks, linear map) runs a cycle-by-cycle control table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_db_lcu_wr_ctrl;

    localparam int DW = 128;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // full-size instance
    logic          start1, rel1, valid1, ready1, cen1, wen1, done1, busy1;
    logic [DW-1:0] data1, dout1;
    logic [AW-1:0] addr1;
    logic [AW:0]   cnt1;
    // small linear instance
    logic          start2, rel2, valid2, ready2, cen2, wen2, done2, busy2;
    logic [DW-1:0] data2, dout2;
    logic [AW-1:0] addr2;
    logic [AW:0]   cnt2;

    db_lcu_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLK_NUM(256), .MAP_RASTER(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .release_i(rel1),
        .blk_valid_i(valid1), .blk_ready_o(ready1), .blk_data_i(data1),
        .cen_o(cen1), .wen_o(wen1), .addr_o(addr1), .data_o(dout1),
        .done_o(done1), .busy_o(busy1), .cnt_o(cnt1));

    db_lcu_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLK_NUM(4), .MAP_RASTER(0)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .release_i(rel2),
        .blk_valid_i(valid2), .blk_ready_o(ready2), .blk_data_i(data2),
        .cen_o(cen2), .wen_o(wen2), .addr_o(addr2), .data_o(dout2),
        .done_o(done2), .busy_o(busy2), .cnt_o(cnt2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input int k);
        return {32'hC0DE0000 + 32'(k), 32'h12345678, ~32'(k), 32'(k)};
    endfunction

    // reference z-scan -> raster address for a 16x16-block LCU
    function automatic int zmap(input int i);
        int col = 0;
        int row = 0;
        for (int b = 0; b < 4; b++) begin
            col += ((i >> (2*b)) & 1) << b;
            row += ((i >> (2*b + 1)) & 1) << b;
        end
        return row * 16 + col;
    endfunction

    // write log of the full-size instance
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            done_at[$];
    int            stray_done = 0;
    int            split_en   = 0;

    always @(negedge clk) begin
        if (cen1 !== wen1) split_en++;
        if (cen1 === 1'b0 && wen1 === 1'b0) begin
            wr_addr.push_back(addr1);
            wr_data.push_back(dout1);
            if (done1) done_at.push_back(wr_addr.size());
        end else if (done1 === 1'b1) begin
            stray_done++;
        end
    end

    task automatic clear_log;
        wr_addr.delete();
        wr_data.delete();
        done_at.delete();
    endtask

    task automatic check_lcu_log(input string tag);
        chk({tag, "_wr_count"}, 128'(wr_addr.size()), 128'd256);
        for (int k = 0; k < wr_addr.size() && k < 256; k++) begin
            chk({tag, "_addr"}, 128'(wr_addr[k]), 128'(zmap(k)));
            chk({tag, "_data"}, wr_data[k], mk(k));
        end
        chk({tag, "_done_count"}, 128'(done_at.size()), 128'd1);
        if (done_at.size() > 0) chk({tag, "_done_on_write"}, 128'(done_at[0]), 128'd256);
    endtask

    // control table for the small instance: inputs, then expected state
    // one edge later
    typedef struct {
        logic st; logic rl; logic v;
        logic rdy; logic bsy; int cnt; logic strobe; logic dn; int addr; int drow;
    } vec_t;

    typedef struct { int idx; int addr; } map_t;

    vec_t tab[19];
    map_t mtab[12];

    initial begin
        //            st  rl  v   rdy bsy cnt stb dn addr drow
        tab[0]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0, 0,1'b0,1'b0, 0, -1};
        tab[1]  = '{1'b1,1'b0,1'b1, 1'b1,1'b1, 0,1'b0,1'b0, 0, -1};
        tab[2]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1, 1,1'b1,1'b0, 0,  2};
        tab[3]  = '{1'b1,1'b1,1'b0, 1'b1,1'b1, 1,1'b0,1'b0, 0,  2};
        tab[4]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1, 2,1'b1,1'b0, 1,  4};
        tab[5]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1, 3,1'b1,1'b0, 2,  5};
        tab[6]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1, 3,1'b0,1'b0, 2,  5};
        tab[7]  = '{1'b0,1'b0,1'b1, 1'b0,1'b1, 4,1'b1,1'b1, 3,  7};
        tab[8]  = '{1'b0,1'b0,1'b1, 1'b0,1'b1, 4,1'b0,1'b0, 3,  7};
        tab[9]  = '{1'b0,1'b0,1'b1, 1'b0,1'b1, 4,1'b0,1'b0, 3,  7};
        tab[10] = '{1'b0,1'b1,1'b0, 1'b0,1'b0, 4,1'b0,1'b0, 3,  7};
        tab[11] = '{1'b1,1'b0,1'b0, 1'b1,1'b1, 0,1'b0,1'b0, 3,  7};
        tab[12] = '{1'b0,1'b0,1'b1, 1'b1,1'b1, 1,1'b1,1'b0, 0, 12};
        tab[13] = '{1'b0,1'b0,1'b1, 1'b1,1'b1, 2,1'b1,1'b0, 1, 13};
        tab[14] = '{1'b0,1'b0,1'b1, 1'b1,1'b1, 3,1'b1,1'b0, 2, 14};
        tab[15] = '{1'b0,1'b0,1'b1, 1'b0,1'b1, 4,1'b1,1'b1, 3, 15};
        tab[16] = '{1'b1,1'b1,1'b1, 1'b1,1'b1, 0,1'b0,1'b0, 3, 15};
        tab[17] = '{1'b0,1'b0,1'b1, 1'b1,1'b1, 1,1'b1,1'b0, 0, 17};
        tab[18] = '{1'b0,1'b1,1'b0, 1'b1,1'b1, 1,1'b0,1'b0, 0, 17};

        // hand-computed z-scan -> raster addresses
        mtab[0]  = '{0, 0};    mtab[1]  = '{1, 1};    mtab[2]  = '{2, 16};
        mtab[3]  = '{3, 17};   mtab[4]  = '{4, 2};    mtab[5]  = '{7, 19};
        mtab[6]  = '{8, 32};   mtab[7]  = '{15, 51};  mtab[8]  = '{16, 4};
        mtab[9]  = '{85, 15};  mtab[10] = '{170, 240}; mtab[11] = '{255, 255};

        rst = 1'b1;
        {start1, rel1, valid1} = 3'b000; data1 = '0;
        {start2, rel2, valid2} = 3'b000; data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cen", 128'(cen1), 128'd1);
        chk("rst_wen", 128'(wen1), 128'd1);
        chk("rst_ready", 128'(ready1), 128'd0);
        chk("rst_cnt", 128'(cnt1), 128'd0);
        chk("rst_busy", 128'(busy1), 128'd0);
        chk("rst_done", 128'(done1), 128'd0);
        chk("rst_addr", 128'(addr1), 128'd0);
        chk("rst_data", dout1, 128'd0);
        rst = 1'b0;
        tick;

        // ---- control table on the 4-block linear instance ----
        for (int r = 0; r < 19; r++) begin
            start2 = tab[r].st; rel2 = tab[r].rl; valid2 = tab[r].v; data2 = mk(r);
            tick;
            chk($sformatf("tab%0d_ready", r), 128'(ready2), 128'(tab[r].rdy));
            chk($sformatf("tab%0d_busy", r), 128'(busy2), 128'(tab[r].bsy));
            chk($sformatf("tab%0d_cnt", r), 128'(cnt2), 128'(tab[r].cnt));
            chk($sformatf("tab%0d_cen", r), 128'(cen2), 128'(!tab[r].strobe));
            chk($sformatf("tab%0d_wen", r), 128'(wen2), 128'(!tab[r].strobe));
            chk($sformatf("tab%0d_done", r), 128'(done2), 128'(tab[r].dn));
            chk($sformatf("tab%0d_addr", r), 128'(addr2), 128'(tab[r].addr));
            chk($sformatf("tab%0d_data", r), dout2, (tab[r].drow < 0) ? '0 : mk(tab[r].drow));
        end
        {start2, rel2, valid2} = 3'b000;

        // ---- full LCU with valid held high ----
        clear_log();
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        chk("t2_busy_start", 128'(busy1), 128'd1);
        chk("t2_ready_start", 128'(ready1), 128'd1);
        chk("t2_cnt_start", 128'(cnt1), 128'd0);
        valid1 = 1'b1;
        for (int k = 0; k < 256; k++) begin
            data1 = mk(k);
            tick;
            if (k < 255) chk("t2_cen_stream", 128'(cen1), 128'd0);
        end
        valid1 = 1'b0;
        chk("t2_last_cen", 128'(cen1), 128'd0);
        chk("t2_last_done", 128'(done1), 128'd1);
        chk("t2_cnt_end", 128'(cnt1), 128'd256);
        chk("t2_ready_end", 128'(ready1), 128'd0);
        chk("t2_busy_end", 128'(busy1), 128'd1);
        tick;
        check_lcu_log("t2");
        for (int m = 0; m < 12; m++) begin
            if (mtab[m].idx < wr_addr.size())
                chk($sformatf("map_%0d", mtab[m].idx), 128'(wr_addr[mtab[m].idx]), 128'(mtab[m].addr));
            else
                chk("map_missing", 128'(wr_addr.size()), 128'(mtab[m].idx + 1));
        end

        // ---- WAIT hold: valid ignored for 10 cycles ----
        valid1 = 1'b1; data1 = mk(999);
        for (int c = 0; c < 10; c++) begin
            tick;
            chk("t4_wait_ready", 128'(ready1), 128'd0);
            chk("t4_wait_cen", 128'(cen1), 128'd1);
        end
        valid1 = 1'b0;
        tick;
        chk("t4_wait_writes", 128'(wr_addr.size()), 128'd256);
        chk("t4_wait_cnt", 128'(cnt1), 128'd256);
        rel1 = 1'b1;
        tick;
        rel1 = 1'b0;
        chk("t4_release_busy", 128'(busy1), 128'd0);
        chk("t4_release_ready", 128'(ready1), 128'd0);

        // ---- bubbles ----
        clear_log();
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        begin
            int k = 0;
            int cyc = 0;
            while (k < 256 && cyc < 5000) begin
                logic v;
                v = ($urandom_range(0, 2) != 0);
                valid1 = v;
                data1  = v ? mk(k) : mk(100000 + cyc);
                tick;
                chk("t3_strobe_vs_accept", 128'(cen1), 128'(!v));
                if (v) k++;
                cyc++;
            end
            valid1 = 1'b0;
            chk("t3_accept_budget", 128'(k), 128'd256);
        end
        tick;
        tick;
        check_lcu_log("t3");

        // ---- release together with start restarts immediately ----
        start1 = 1'b1; rel1 = 1'b1;
        tick;
        start1 = 1'b0; rel1 = 1'b0;
        chk("t4_restart_busy", 128'(busy1), 128'd1);
        chk("t4_restart_ready", 128'(ready1), 128'd1);
        chk("t4_restart_cnt", 128'(cnt1), 128'd0);

        // ---- ignored controls in LOAD ----
        valid1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data1 = mk(k);
            tick;
        end
        valid1 = 1'b0;
        chk("t5_cnt3", 128'(cnt1), 128'd3);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        chk("t5_start_cnt", 128'(cnt1), 128'd3);
        chk("t5_start_ready", 128'(ready1), 128'd1);
        rel1 = 1'b1;
        tick;
        rel1 = 1'b0;
        chk("t5_release_cnt", 128'(cnt1), 128'd3);
        chk("t5_release_busy", 128'(busy1), 128'd1);

        // ---- asynchronous reset with a write strobe pending ----
        valid1 = 1'b1; data1 = mk(3);
        tick;
        valid1 = 1'b0;
        chk("t1_pre_cen", 128'(cen1), 128'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_cen", 128'(cen1), 128'd1);
        chk("t1_wen", 128'(wen1), 128'd1);
        chk("t1_ready", 128'(ready1), 128'd0);
        chk("t1_cnt", 128'(cnt1), 128'd0);
        chk("t1_busy", 128'(busy1), 128'd0);
        tick;
        rst = 1'b0;
        tick;
        rel1 = 1'b1;
        tick;
        rel1 = 1'b0;
        chk("t5_idle_release_busy", 128'(busy1), 128'd0);
        chk("t5_idle_release_ready", 128'(ready1), 128'd0);

        chk("stray_done", 128'(stray_done), 128'd0);
        chk("split_enables", 128'(split_en), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
